// File: rtl/cavlc_pkg.sv
// Shared types and width helpers for the CAVLC bit packer.
package cavlc_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam int CODE_W_DEF = 16;
  localparam int LEN_W_DEF  = 5;
  localparam int OUT_W_DEF  = 32;

  function automatic int acc_w(input int out_w, input int code_w);
    return out_w + code_w;
  endfunction

  function automatic int fill_w(input int out_w, input int code_w);
    return $clog2(out_w + code_w + 1);
  endfunction

  function automatic int nbits_w(input int out_w);
    return $clog2(out_w) + 1;
  endfunction

  localparam int ACC_W   = acc_w(OUT_W_DEF, CODE_W_DEF);
  localparam int FILL_W  = fill_w(OUT_W_DEF, CODE_W_DEF);
  localparam int NBITS_W = nbits_w(OUT_W_DEF);

endpackage

// File: rtl/cavlc_bit_align.sv
// Masks a right-aligned code to its length and places its MSB at accumulator bit ACC_W-1-fill.
module cavlc_bit_align
  import cavlc_pkg::*;
#(
  parameter int CODE_W = 16,
  parameter int LEN_W  = 5,
  parameter int ACC_W  = 48,
  parameter int FILL_W = 6
) (
  input  logic [CODE_W-1:0] code_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [FILL_W-1:0] fill_i,
  output logic [ACC_W-1:0]  aligned_o
);

  logic [CODE_W:0]   lenOneHot;
  logic [CODE_W-1:0] codeMask;
  logic [CODE_W-1:0] codeMasked;
  logic [FILL_W-1:0] shiftAmt;

  // len_i is already clamped to CODE_W, and fill+len < ACC_W, so the shift never underflows.
  always_comb begin
    lenOneHot  = (CODE_W + 1)'(1) << len_i;
    codeMask   = CODE_W'(lenOneHot - (CODE_W + 1)'(1));
    codeMasked = code_i & codeMask;
    shiftAmt   = FILL_W'(ACC_W) - fill_i - FILL_W'(len_i);
    aligned_o  = ACC_W'(codeMasked) << shiftAmt;
  end

endmodule

// File: rtl/cavlc_bit_packer.sv
// Packs variable-length codes MSB-first into OUT_W-bit words; a flush-qualified symbol
// closes the stream with a zero-padded word tagged last.
module cavlc_bit_packer
  import cavlc_pkg::*;
#(
  parameter int CODE_W = 16,
  parameter int LEN_W  = 5,
  parameter int OUT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [CODE_W-1:0]      in_code_i,
  input  logic [LEN_W-1:0]       in_len_i,
  input  logic                   in_flush_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [OUT_W-1:0]       out_data_o,
  output logic [$clog2(OUT_W):0] out_nbits_o,
  output logic                   out_last_o,
  output logic                   err_len_o
);

  localparam int ACC_W   = acc_w(OUT_W, CODE_W);
  localparam int FILL_W  = fill_w(OUT_W, CODE_W);
  localparam int NBITS_W = nbits_w(OUT_W);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              err_len_q, err_len_d;

  logic              lenTooLong;
  logic [LEN_W-1:0]  lenClamped;
  logic [ACC_W-1:0]  alignedCode;
  logic              fullWord;
  logic              lastWord;
  logic              accept;
  logic              emit;

  assign lenTooLong = in_len_i > LEN_W'(CODE_W);
  assign lenClamped = lenTooLong ? LEN_W'(CODE_W) : in_len_i;

  cavlc_bit_align #(
    .CODE_W(CODE_W),
    .LEN_W (LEN_W),
    .ACC_W (ACC_W),
    .FILL_W(FILL_W)
  ) u_align (
    .code_i   (in_code_i),
    .len_i    (lenClamped),
    .fill_i   (fill_q),
    .aligned_o(alignedCode)
  );

  // Every output is decoded from registered state only; accept and emit are mutually exclusive.
  assign fullWord    = fill_q >= FILL_W'(OUT_W);
  assign lastWord    = (state_q == FLUSH) && (fill_q <= FILL_W'(OUT_W));
  assign in_ready_o  = (state_q == RUN) && !fullWord;
  assign out_valid_o = (state_q == FLUSH) || fullWord;
  assign out_data_o  = acc_q[ACC_W-1 -: OUT_W];
  assign out_nbits_o = !out_valid_o ? '0 : (lastWord ? NBITS_W'(fill_q) : NBITS_W'(OUT_W));
  assign out_last_o  = lastWord;
  assign err_len_o   = err_len_q;

  assign accept = in_valid_i && in_ready_o;
  assign emit   = out_valid_o && out_ready_i;

  always_comb begin
    acc_d     = acc_q;
    fill_d    = fill_q;
    state_d   = state_q;
    err_len_d = err_len_q;
    if (accept) begin
      acc_d     = acc_q | alignedCode;
      fill_d    = fill_q + FILL_W'(lenClamped);
      err_len_d = err_len_q | lenTooLong;
      if (in_flush_i) state_d = FLUSH;
    end else if (emit) begin
      if (lastWord) begin
        acc_d   = '0;
        fill_d  = '0;
        state_d = RUN;
      end else begin
        acc_d  = acc_q << OUT_W;
        fill_d = fill_q - FILL_W'(OUT_W);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      fill_q    <= '0;
      state_q   <= RUN;
      err_len_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      err_len_q <= err_len_d;
    end
  end

endmodule
